// File: rtl/ncl_mult_seq.sv
// ncl_mult_seq: clocked dual-rail (NCL-style) shift-add multiplier.
// Operands arrive as WIDTH-bit dual-rail words under a four-phase Ki/Ko
// return-to-NULL handshake; the 2*WIDTH-bit product is presented dual-rail.
// SIGNED = 1 multiplies magnitudes and fixes the sign in one extra cycle.
// Optional build macro: NCL_MULT_ILLEGAL_DET_EN enables the sticky err flag
// for operand bits seen at the illegal 11 codeword while waiting for DATA.
module ncl_mult_seq #(
  parameter int WIDTH  = 3,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A_rail1,
  input  logic [WIDTH-1:0]     A_rail0,
  input  logic [WIDTH-1:0]     B_rail1,
  input  logic [WIDTH-1:0]     B_rail0,
  input  logic                 Ki,
  output logic [2*WIDTH-1:0]   Po_rail1,
  output logic [2*WIDTH-1:0]   Po_rail0,
  output logic                 Ko,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_WAIT_DATA,
    S_CALC,
    S_FIX,
    S_WAIT_KI,
    S_PRESENT,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;      // multiplicand, shifted left one place per step
  logic [WIDTH-1:0] b_q, b_d;     // multiplier, shifted right one place per step
  logic            neg_q, neg_d;  // operand signs differ (signed mode only)
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   po1_q, po1_d;
  logic [PW-1:0]   po0_q, po0_d;
  logic            ko_q, ko_d;

  // Codeword classification of the incoming operand words.
  logic ops_complete, ops_null;
  assign ops_complete = (&(A_rail1 ^ A_rail0)) & (&(B_rail1 ^ B_rail0));
  assign ops_null     = ~(|{A_rail1, A_rail0, B_rail1, B_rail0});

  // Magnitudes and signs: the shift-add core only ever sees non-negative values.
  // The most-negative operand's magnitude still fits in WIDTH unsigned bits.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sign_a = (SIGNED != 0) && A_rail1[WIDTH-1];
  assign sign_b = (SIGNED != 0) && B_rail1[WIDTH-1];
  assign a_mag  = sign_a ? (~A_rail1 + WIDTH'(1)) : A_rail1;
  assign b_mag  = sign_b ? (~B_rail1 + WIDTH'(1)) : B_rail1;

`ifdef NCL_MULT_ILLEGAL_DET_EN
  logic ops_illegal;
  logic err_q, err_d;
  assign ops_illegal = (|(A_rail1 & A_rail0)) | (|(B_rail1 & B_rail0));
`endif

  // Next-state logic for the handshake FSM and the shift-add datapath.
  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves a variable
    // unassigned; without these defaults synthesis would infer latches.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    po1_d   = po1_q;
    po0_d   = po0_q;
    ko_d    = ko_q;
`ifdef NCL_MULT_ILLEGAL_DET_EN
    err_d   = err_q;
`endif

    case (state_q)
      S_WAIT_DATA: begin
`ifdef NCL_MULT_ILLEGAL_DET_EN
        if (ops_illegal) err_d = 1'b1;
`endif
        // An 11 bit fails the XOR test, so illegal words are never captured.
        if (ops_complete) begin
          a_d     = {{WIDTH{1'b0}}, a_mag};
          b_d     = b_mag;
          neg_d   = sign_a ^ sign_b;
          acc_d   = '0;
          cnt_d   = '0;
          ko_d    = 1'b0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = (SIGNED != 0) ? S_FIX : S_WAIT_KI;
        end
      end

      S_FIX: begin
        if (neg_q) acc_d = ~acc_q + PW'(1);
        state_d = S_WAIT_KI;
      end

      S_WAIT_KI: begin
        if (Ki) begin
          po1_d   = acc_q;
          po0_d   = ~acc_q;
          state_d = S_PRESENT;
        end
      end

      S_PRESENT: begin
        // Ki must fall before the next result can ever be presented.
        if (!Ki) begin
          po1_d   = '0;
          po0_d   = '0;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (ops_null) begin
          ko_d    = 1'b1;
          state_d = S_WAIT_DATA;
        end
      end

      default: begin
        po1_d   = '0;
        po0_d   = '0;
        ko_d    = 1'b0;
        state_d = S_FLUSH;
      end
    endcase
  end

  // State and output registers; reset discards any result in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FLUSH;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      po1_q   <= '0;
      po0_q   <= '0;
      ko_q    <= 1'b0;
`ifdef NCL_MULT_ILLEGAL_DET_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values regardless of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      po1_q   <= po1_d;
      po0_q   <= po0_d;
      ko_q    <= ko_d;
`ifdef NCL_MULT_ILLEGAL_DET_EN
      err_q   <= err_d;
`endif
    end
  end

  assign Po_rail1 = po1_q;
  assign Po_rail0 = po0_q;
  assign Ko       = ko_q;
  assign busy     = (state_q != S_WAIT_DATA);
`ifdef NCL_MULT_ILLEGAL_DET_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
